// File: rtl/data_memory.sv
// Word-organised MEM-stage data memory: byte/half/word stores with lane merging,
// extended sub-word loads, address exceptions and a post-reset clear sweep.
module data_memory #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DEPTH      = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  writeEnable,
   input  logic                  readEnable,
   input  logic [1:0]            accessSize,
   input  logic                  signExtend,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           writeDataIn,
   output logic [31:0]           readData,
   output logic                  exception,
   output logic                  busy
);

   localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_e;

   state_e           state_q;
   logic [IDX_W-1:0] clear_idx_q;
   logic [31:0]      mem_q [DEPTH];

   logic [WIDX_W-1:0] word_idx;
   logic [IDX_W-1:0]  mem_idx;
   logic              is_byte;
   logic              is_half;
   logic              misaligned;
   logic              out_of_range;
   logic              store_ok_c;
   logic              load_ok_c;
   logic [3:0]        byte_en_c;
   logic [31:0]       wr_lanes_c;
   logic [31:0]       rd_word_c;
   logic [7:0]        rd_byte_c;
   logic [15:0]       rd_half_c;

   assign word_idx = address[ADDR_WIDTH-1:2];
   assign mem_idx  = IDX_W'(word_idx);
   assign busy     = (state_q == ST_CLEAR);

   // Request decode and address checking
   always_comb begin
      is_byte      = (accessSize == 2'b00);
      is_half      = (accessSize == 2'b01);
      misaligned   = (is_half & address[0]) |
                     (~is_byte & ~is_half & (address[1:0] != 2'b00));
      out_of_range = (32'(word_idx) >= 32'(DEPTH));
      exception    = (readEnable | writeEnable) & ~busy & (misaligned | out_of_range);
      store_ok_c   = writeEnable & ~busy & ~exception;
      load_ok_c    = readEnable & ~busy & ~exception;
   end

   // Store lane enables; data is replicated so every lane sees its slice
   always_comb begin
      byte_en_c  = 4'b1111;
      wr_lanes_c = writeDataIn;
      if (is_byte) begin
         byte_en_c  = 4'b0001 << address[1:0];
         wr_lanes_c = {4{writeDataIn[7:0]}};
      end else if (is_half) begin
         byte_en_c  = address[1] ? 4'b1100 : 4'b0011;
         wr_lanes_c = {2{writeDataIn[15:0]}};
      end
   end

   // Combinational load path with lane select and extension
   always_comb begin
      rd_word_c = mem_q[mem_idx];
      rd_byte_c = rd_word_c[{address[1:0], 3'b000} +: 8];
      rd_half_c = address[1] ? rd_word_c[31:16] : rd_word_c[15:0];
      readData  = '0;
      if (load_ok_c) begin
         if (is_byte) begin
            readData = {{24{signExtend & rd_byte_c[7]}}, rd_byte_c};
         end else if (is_half) begin
            readData = {{16{signExtend & rd_half_c[15]}}, rd_half_c};
         end else begin
            readData = rd_word_c;
         end
      end
   end

   // Clear sweep FSM and the single shared write port
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         clear_idx_q <= '0;
      end else if (state_q == ST_CLEAR) begin
         mem_q[clear_idx_q] <= '0;
         if (clear_idx_q == LAST_IDX) begin
            state_q <= ST_READY;
         end else begin
            clear_idx_q <= clear_idx_q + IDX_W'(1);
         end
      end else if (store_ok_c) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en_c[b]) begin
               mem_q[mem_idx][8*b +: 8] <= wr_lanes_c[8*b +: 8];
            end
         end
      end
   end

endmodule
